// File: rtl/fmc_apb_seq.sv
// ---------------------------------------------------------------------------
// fmc_apb_seq
// Converts asynchronous FMC slave strobes (NE/NOE/NWE with A and D) into
// single APB3 transfers on clk. The strobes are synchronized and
// edge-detected. Address and data are captured, and the APB SETUP/ACCESS
// handshake is run. Read data is returned to the FMC pins with output-enable
// control. Slave errors, PREADY timeouts and host protocol violations are
// flagged in sticky bits.
//
// Ports
//   clk, resetn                 system clock, async active-low reset
//   io_fmc_A / io_fmc_D_in      FMC address / write data from host
//   io_fmc_D_out / io_fmc_D_oe  read data and pin output enable to host
//   io_fmc_NE/NOE/NWE           FMC strobes, active low, asynchronous
//   io_fmc_NWAIT                wait to host, active low
//   PADDR..PSLVERR              APB3 master port
//   clr_err                     pulse, clears the sticky error flags
//   busy                        sequencer not idle
//   err_slv/err_timeout/err_proto  sticky error flags
//
// Build option
//   FMC_NWAIT_EN  defined: NWAIT is driven low while an APB transfer is
//                 pending. Undefined: NWAIT is tied high.
//
// state  | meaning
// IDLE   | waiting for a synced NWE/NOE falling edge with NE low
// SETUP  | APB setup phase, PSEL=1 PENABLE=0, one cycle
// ACCESS | APB access phase, waiting for PREADY or timeout
// HOLD   | transfer done, drive read data until NE goes high
// ---------------------------------------------------------------------------
module fmc_apb_seq #(
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] io_fmc_A,
    input  logic [DATA_W-1:0] io_fmc_D_in,
    output logic [DATA_W-1:0] io_fmc_D_out,
    output logic              io_fmc_D_oe,
    input  logic              io_fmc_NE,
    input  logic              io_fmc_NOE,
    input  logic              io_fmc_NWE,
    output logic              io_fmc_NWAIT,
    output logic [ADDR_W+1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic              clr_err,
    output logic              busy,
    output logic              err_slv,
    output logic              err_timeout,
    output logic              err_proto
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // ACCESS lasts TIMEOUT cycles: the counter is loaded with TIMEOUT-1 and
    // the abort fires on the cycle it reads zero.
    localparam logic [7:0]        TO_LOAD  = 8'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] TO_RDATA = DATA_W'(32'hDEAD_BEEF);

    // ---------------------------------------------------------------------
    // Strobe synchronizers, bit order {NE, NOE, NWE}
    // ---------------------------------------------------------------------
    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] dly_q;
    logic [2:0] strb_s;
    logic       ne_s, noe_s;
    logic       ne_rise, noe_rise, nwe_rise;
    logic       noe_fall, nwe_fall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 3'b111;
            end
            dly_q <= 3'b111;
        end else begin
            sync_q[0] <= {io_fmc_NE, io_fmc_NOE, io_fmc_NWE};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign strb_s   = sync_q[SYNC_STAGES-1];
    assign ne_s     = strb_s[2];
    assign noe_s    = strb_s[1];
    assign ne_rise  = strb_s[2] & ~dly_q[2];
    assign noe_rise = strb_s[1] & ~dly_q[1];
    assign nwe_rise = strb_s[0] & ~dly_q[0];
    assign noe_fall = ~strb_s[1] & dly_q[1];
    assign nwe_fall = ~strb_s[0] & dly_q[0];

    // ---------------------------------------------------------------------
    // Sequencer registers
    // ---------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [ADDR_W+1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [7:0]        cnt_q, cnt_d;
    // Set when the host broke off the current transfer early; it keeps the
    // data pins from being driven in HOLD.
    logic              acc_proto_q, acc_proto_d;
    logic              err_slv_q, err_slv_d;
    logic              err_to_q, err_to_d;
    logic              err_proto_q, err_proto_d;
    logic              set_slv, set_to, set_proto;
    logic              strobe_rise;

    assign strobe_rise = ne_rise | (pwrite_q ? nwe_rise : noe_rise);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            dout_q      <= '0;
            cnt_q       <= '0;
            acc_proto_q <= 1'b0;
            err_slv_q   <= 1'b0;
            err_to_q    <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            dout_q      <= dout_d;
            cnt_q       <= cnt_d;
            acc_proto_q <= acc_proto_d;
            err_slv_q   <= err_slv_d;
            err_to_q    <= err_to_d;
            err_proto_q <= err_proto_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        dout_d      = dout_q;
        cnt_d       = cnt_q;
        acc_proto_d = acc_proto_q;
        set_slv     = 1'b0;
        set_to      = 1'b0;
        set_proto   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!ne_s && (nwe_fall || noe_fall)) begin
                    paddr_d     = {io_fmc_A, 2'b00};
                    acc_proto_d = 1'b0;
                    cnt_d       = TO_LOAD;
                    state_d     = SETUP;
                    if (nwe_fall) begin
                        // A write wins when both strobes fall together.
                        pwrite_d  = 1'b1;
                        pwdata_d  = io_fmc_D_in;
                        set_proto = noe_fall;
                    end else begin
                        pwrite_d = 1'b0;
                    end
                end
            end

            SETUP: begin
                cnt_d   = TO_LOAD;
                state_d = ACCESS;
                if (strobe_rise) begin
                    set_proto   = 1'b1;
                    acc_proto_d = 1'b1;
                end
            end

            ACCESS: begin
                if (strobe_rise) begin
                    set_proto   = 1'b1;
                    acc_proto_d = 1'b1;
                end
                if (PREADY) begin
                    if (!pwrite_q) begin
                        dout_d = PRDATA;
                    end
                    set_slv = PSLVERR;
                    state_d = HOLD;
                end else if (cnt_q == 8'd0) begin
                    if (!pwrite_q) begin
                        dout_d = TO_RDATA;
                    end
                    set_to  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            HOLD: begin
                // Level test so an NE release seen earlier, during an
                // aborted access, still returns the FSM to IDLE.
                if (ne_s) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // A set event in the same cycle as clr_err takes priority.
        err_slv_d   = (err_slv_q   & ~clr_err) | set_slv;
        err_to_d    = (err_to_q    & ~clr_err) | set_to;
        err_proto_d = (err_proto_q & ~clr_err) | set_proto;
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign PADDR        = paddr_q;
    assign PWRITE       = pwrite_q;
    assign PWDATA       = pwdata_q;
    assign PSEL         = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE      = (state_q == ACCESS);
    assign busy         = (state_q != IDLE);
    assign io_fmc_D_out = dout_q;
    assign io_fmc_D_oe  = (state_q == HOLD) && !pwrite_q && !noe_s && !acc_proto_q;
    assign err_slv      = err_slv_q;
    assign err_timeout  = err_to_q;
    assign err_proto    = err_proto_q;

`ifdef FMC_NWAIT_EN
    // Low from strobe capture until ACCESS completes, which is exactly the
    // time spent in SETUP and ACCESS.
    assign io_fmc_NWAIT = !((state_q == SETUP) || (state_q == ACCESS));
`else
    assign io_fmc_NWAIT = 1'b1;
`endif

endmodule

// File: tb/tb_fmc_apb_seq.sv
module tb_fmc_apb_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic [25:0] io_fmc_A;
    logic [31:0] io_fmc_D_in;
    logic [31:0] io_fmc_D_out;
    logic        io_fmc_D_oe;
    logic        io_fmc_NE, io_fmc_NOE, io_fmc_NWE;
    logic        io_fmc_NWAIT;
    logic [27:0] PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        clr_err, busy, err_slv, err_timeout, err_proto;

    int tests = 0;
    int fails = 0;
    int pen_cnt;

`ifdef FMC_NWAIT_EN
    localparam logic NWAIT_BUSY = 1'b0;
`else
    localparam logic NWAIT_BUSY = 1'b1;
`endif

    fmc_apb_seq dut (
        .clk(clk), .resetn(resetn),
        .io_fmc_A(io_fmc_A), .io_fmc_D_in(io_fmc_D_in),
        .io_fmc_D_out(io_fmc_D_out), .io_fmc_D_oe(io_fmc_D_oe),
        .io_fmc_NE(io_fmc_NE), .io_fmc_NOE(io_fmc_NOE), .io_fmc_NWE(io_fmc_NWE),
        .io_fmc_NWAIT(io_fmc_NWAIT),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .clr_err(clr_err), .busy(busy), .err_slv(err_slv),
        .err_timeout(err_timeout), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Assert NE, then the chosen strobe; returns at the negedge of the SETUP
    // cycle, which is SYNC_STAGES+1 clocks after the strobe pin fell.
    task automatic begin_xfer(input logic [25:0] a, input logic wr, input logic [31:0] d);
        io_fmc_A    = a;
        io_fmc_D_in = d;
        io_fmc_NE   = 1'b0;
        tick(3);
        if (wr) io_fmc_NWE = 1'b0;
        else    io_fmc_NOE = 1'b0;
        tick(2);
        chk("lat_no_psel_yet", {63'd0, PSEL}, 64'd0);
        tick(1);
        chk("lat_psel_setup", {62'd0, PSEL, PENABLE}, 64'b10);
    endtask

    task automatic end_xfer();
        io_fmc_NE  = 1'b1;
        io_fmc_NOE = 1'b1;
        io_fmc_NWE = 1'b1;
        tick(3);
        chk("end_idle", {62'd0, busy, io_fmc_D_oe}, 64'd0);
    endtask

    initial begin
        resetn = 1'b0;
        io_fmc_A = '0; io_fmc_D_in = '0;
        io_fmc_NE = 1'b1; io_fmc_NOE = 1'b1; io_fmc_NWE = 1'b1;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0; clr_err = 1'b0;
        tick(2);
        chk("rst_apb", {34'd0, PADDR, PSEL, PENABLE}, 64'd0);
        chk("rst_wr", {31'd0, PWRITE, PWDATA}, 64'd0);
        chk("rst_dout", {31'd0, io_fmc_D_oe, io_fmc_D_out}, 64'd0);
        chk("rst_misc", {59'd0, io_fmc_NWAIT, busy, err_slv, err_timeout, err_proto}, 64'b10000);
        resetn = 1'b1;
        tick(2);

        // ---- basic read, PREADY in first ACCESS cycle
        PRDATA = 32'h1234_5678; PREADY = 1'b1;
        begin_xfer(26'h4000, 1'b0, 32'h0);
        chk("rd_paddr", {36'd0, PADDR}, 64'h0010000);
        chk("rd_pwrite", {62'd0, PWRITE, busy}, 64'b01);
        chk("rd_nwait_setup", {63'd0, io_fmc_NWAIT}, {63'd0, NWAIT_BUSY});
        tick(1);
        chk("rd_access", {62'd0, PSEL, PENABLE}, 64'b11);
        chk("rd_no_oe_access", {63'd0, io_fmc_D_oe}, 64'd0);
        tick(1);
        chk("rd_hold", {61'd0, PSEL, PENABLE, io_fmc_D_oe}, 64'b001);
        chk("rd_dout", {32'd0, io_fmc_D_out}, 64'h1234_5678);
        tick(3);
        chk("rd_hold_keep", {31'd0, io_fmc_D_oe, io_fmc_D_out}, {31'd0, 1'b1, 32'h1234_5678});
        chk("rd_flags", {61'd0, err_slv, err_timeout, err_proto}, 64'd0);
        PREADY = 1'b0;
        end_xfer();

        // ---- write
        PREADY = 1'b1;
        begin_xfer(26'h0010, 1'b1, 32'hCAFE_F00D);
        chk("wr_paddr", {36'd0, PADDR}, 64'h40);
        chk("wr_pwdata", {31'd0, PWRITE, PWDATA}, {31'd0, 1'b1, 32'hCAFE_F00D});
        chk("wr_oe_setup", {63'd0, io_fmc_D_oe}, 64'd0);
        tick(1);
        chk("wr_access", {61'd0, PSEL, PENABLE, io_fmc_D_oe}, 64'b110);
        tick(1);
        chk("wr_hold", {61'd0, PSEL, busy, io_fmc_D_oe}, 64'b010);
        chk("wr_flags", {61'd0, err_slv, err_timeout, err_proto}, 64'd0);
        PREADY = 1'b0;
        end_xfer();

        // ---- wait states plus slave error
        PRDATA = 32'hA5A5_0001;
        begin_xfer(26'h0003, 1'b0, 32'h0);
        pen_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (PENABLE) pen_cnt++;
        end
        PREADY = 1'b1; PSLVERR = 1'b1;
        tick(1);
        chk("ws_penable_cycles", 64'(pen_cnt), 64'd4);
        chk("ws_hold", {62'd0, PENABLE, io_fmc_D_oe}, 64'b01);
        chk("ws_dout", {32'd0, io_fmc_D_out}, 64'hA5A5_0001);
        chk("ws_err_slv", {62'd0, err_slv, err_proto}, 64'b10);
        PREADY = 1'b0; PSLVERR = 1'b0;
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("ws_clr", {63'd0, err_slv}, 64'd0);
        end_xfer();

        // ---- timeout, with clr_err colliding with the timeout event
        begin_xfer(26'h0022, 1'b0, 32'h0);
        pen_cnt = 0;
        for (int i = 1; i <= 255; i++) begin
            tick(1);
            if (PENABLE) pen_cnt++;
            if (i == 255) clr_err = 1'b1;
        end
        chk("to_nwait_access", {63'd0, io_fmc_NWAIT}, {63'd0, NWAIT_BUSY});
        tick(1);
        clr_err = 1'b0;
        chk("to_cycles", 64'(pen_cnt), 64'd255);
        chk("to_psel", {62'd0, PSEL, PENABLE}, 64'd0);
        chk("to_dout", {32'd0, io_fmc_D_out}, 64'hDEAD_BEEF);
        chk("to_err_set_wins", {62'd0, err_timeout, err_slv}, 64'b10);
        chk("to_nwait_hold", {63'd0, io_fmc_NWAIT}, 64'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("to_clr", {63'd0, err_timeout}, 64'd0);
        end_xfer();

        // ---- protocol error: NE released during ACCESS, NOE stays low
        PRDATA = 32'h0000_BEEF;
        begin_xfer(26'h0005, 1'b0, 32'h0);
        tick(1);
        io_fmc_NE = 1'b1;
        tick(3);
        chk("pe_flag", {62'd0, err_proto, PENABLE}, 64'b11);
        PREADY = 1'b1;
        tick(1);
        PREADY = 1'b0;
        chk("pe_hold_no_oe", {61'd0, busy, PSEL, io_fmc_D_oe}, 64'b100);
        chk("pe_dout", {32'd0, io_fmc_D_out}, 64'h0000_BEEF);
        tick(1);
        chk("pe_idle", {62'd0, busy, io_fmc_D_oe}, 64'd0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("pe_clr", {63'd0, err_proto}, 64'd0);
        end_xfer();

        // ---- NOE and NWE fall together: handled as a write plus error
        PREADY = 1'b1;
        io_fmc_A = 26'h0007; io_fmc_D_in = 32'h0101_0202; io_fmc_NE = 1'b0;
        tick(3);
        io_fmc_NOE = 1'b0; io_fmc_NWE = 1'b0;
        tick(3);
        chk("both_write", {30'd0, PSEL, PWRITE, PWDATA}, {30'd0, 2'b11, 32'h0101_0202});
        chk("both_proto", {63'd0, err_proto}, 64'd1);
        tick(2);
        chk("both_no_oe", {62'd0, busy, io_fmc_D_oe}, 64'b10);
        PREADY = 1'b0;
        end_xfer();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;

        // ---- reset in the middle of ACCESS, then a normal read
        begin_xfer(26'h0009, 1'b0, 32'h0);
        tick(2);
        chk("rr_in_access", {63'd0, PENABLE}, 64'd1);
        resetn = 1'b0;
        #1;
        chk("rr_async", {60'd0, PSEL, PENABLE, io_fmc_D_oe, busy}, 64'd0);
        chk("rr_dout", {31'd0, io_fmc_NWAIT, io_fmc_D_out}, {31'd0, 1'b1, 32'd0});
        io_fmc_NE = 1'b1; io_fmc_NOE = 1'b1;
        tick(1);
        resetn = 1'b1;
        tick(2);
        PRDATA = 32'h0BAD_F00D; PREADY = 1'b1;
        begin_xfer(26'h0100, 1'b0, 32'h0);
        chk("rr2_paddr", {36'd0, PADDR}, 64'h400);
        tick(2);
        chk("rr2_hold", {31'd0, io_fmc_D_oe, io_fmc_D_out}, {31'd0, 1'b1, 32'h0BAD_F00D});
        chk("rr2_flags", {61'd0, err_slv, err_timeout, err_proto}, 64'd0);
        PREADY = 1'b0;
        end_xfer();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fmc_apb_seq.md
Name: fmc_apb_seq

Overview:
Sequencer that turns asynchronous FMC slave strobes (NE/NOE/NWE, A, D) into single APB3 transfers on the system clock. It synchronizes strobes, captures address/data, runs the APB SETUP/ACCESS handshake, returns read data to the FMC pins with output-enable control, and flags timeouts and host protocol violations. Sits between the FMC pin interface and the APB3 interconnect inside the FMC-to-APB top.

Parameters:
ADDR_W, 26, FMC address width (word address)
DATA_W, 32, FMC/APB data width
SYNC_STAGES, 2, flops per strobe synchronizer (min 2)
TIMEOUT, 255, max ACCESS cycles waiting for PREADY (8-bit counter)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
io_fmc_A  in  ADDR_W  FMC address
io_fmc_D_in  in  DATA_W  FMC data from host
io_fmc_D_out  out  DATA_W  read data to host
io_fmc_D_oe  out  1  pin output enable for D
io_fmc_NE  in  1  chip enable, active low
io_fmc_NOE  in  1  output enable, active low
io_fmc_NWE  in  1  write enable, active low
io_fmc_NWAIT  out  1  wait to host, active low
PADDR  out  ADDR_W+2  APB byte address = {A,2'b00}
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error
clr_err  in  1  pulse: clear sticky flags
busy  out  1  FSM not IDLE
err_slv  out  1  sticky, PSLVERR seen
err_timeout  out  1  sticky, PREADY timeout
err_proto  out  1  sticky, host protocol violation

Behaviour:
- Clock clk; reset resetn asynchronous, active-low. Reset: all outputs 0 except io_fmc_NWAIT=1; sync flops reset to 1; FSM IDLE; D_out=0.
- NE/NOE/NWE each pass SYNC_STAGES flops; edge detect on synced value vs. one extra registered copy. A and D_in are sampled unsynchronized, only on the capture cycles below (host guarantees stability).
- States: IDLE, SETUP, ACCESS, HOLD.
- IDLE: synced NE=0 and NWE falling edge -> latch A to PADDR, D_in to PWDATA, PWRITE=1, ->SETUP. Synced NE=0 and NOE falling edge -> latch A, PWRITE=0, ->SETUP. Both falling same cycle -> treat as write, set err_proto.
- SETUP: PSEL=1, PENABLE=0, exactly one cycle -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1; timeout counter cleared on entry, increments each cycle. PREADY=1 -> read: PRDATA captured to D_out; PSLVERR=1 sets err_slv; PSEL/PENABLE drop next cycle; ->HOLD. Counter reaching TIMEOUT without PREADY -> abort: PSEL/PENABLE=0, D_out=32'hDEAD_BEEF (reads), err_timeout=1, ->HOLD.
- Read latency: NOE pin fall to PSEL = SYNC_STAGES+1 clocks; PREADY to D_oe = 1 clock.
- HOLD: io_fmc_D_oe = !PWRITE && synced NOE==0. Synced NE rising -> D_oe=0 next cycle, ->IDLE. NOE high and low again within one NE assertion is ignored (one transfer per NE cycle).
- Synced NE or the active strobe rising while in SETUP/ACCESS: transfer still completes on APB, err_proto=1, D_oe stays 0 for that access.
- D_oe is never 1 outside HOLD.
- Sticky flags clear on clr_err; a setting event in the same cycle wins.
- busy = (state != IDLE).

Optional Feature:
FMC_NWAIT_EN: defined -> io_fmc_NWAIT=0 from synced-strobe capture until ACCESS completes (PREADY or timeout), 1 otherwise; host can insert waits. Undefined -> io_fmc_NWAIT constant 1; host must use fixed timing long enough to cover the worst-case read latency.

Test Plan:
- Read: NE=0, A=26'h4000, NOE=0, PRDATA=32'h1234_5678, PREADY=1 first ACCESS cycle -> PADDR=28'h0010000, PWRITE=0, SETUP 1 clk then ACCESS 1 clk, D_oe=1 with D_out=32'h1234_5678 until NE high; no flags set.
- Write: A=26'h0010, D_in=32'hCAFE_F00D, NWE pulse -> one APB write, PADDR=28'h40, PWDATA=32'hCAFE_F00D, PWRITE=1; D_oe stays 0 throughout.
- Wait states: PREADY low 3 ACCESS cycles, PSLVERR=1 with PREADY -> PENABLE held 4 cycles, err_slv=1; clr_err pulse -> err_slv=0.
- Timeout: read, PREADY tied 0 -> PSEL drops after 255 ACCESS cycles, D_out=32'hDEAD_BEEF, err_timeout=1; with FMC_NWAIT_EN, NWAIT returns to 1.
- Protocol error: NE raised 1 clk after SETUP -> APB transfer completes, D_oe stays 0, err_proto=1, FSM returns to IDLE.
- Reset mid-ACCESS: resetn=0 while PENABLE=1 -> PSEL/PENABLE/D_oe/busy=0 immediately; after release, next FMC read executes normally.
